// File: rtl/hilo_muldiv_ctrl.sv
// HI/LO multiply/divide controller: radix-2 shift-add multiply and restoring divide
// over WIDTH iterations, with sign fix-up and the architectural High/Low registers.
module hilo_muldiv_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [5:0]       InstructionOp,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic             div0,
  output logic [WIDTH-1:0] High,
  output logic [WIDTH-1:0] Low,
  output logic [1:0]       dbg_state
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MTLO  = 6'b010011;

  localparam int CW = $clog2(WIDTH + 1);

  logic [1:0]         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               is_div_q, is_div_d;
  logic               neg_q, neg_d;
  logic               rneg_q, rneg_d;
  logic               div0_q, div0_d;

  logic               op_mul, op_div, op_sgn, op_mthi, op_mtlo, op_valid;
  logic               accept;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH-1:0]   rem_diff;
  logic               rem_ge;
  logic [2*WIDTH-1:0] mul_next, div_next, prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  always_comb begin
    op_mul  = 1'b0;
    op_div  = 1'b0;
    op_sgn  = 1'b0;
    op_mthi = 1'b0;
    op_mtlo = 1'b0;
    case (InstructionOp)
      F_MULT:  begin op_mul = 1'b1; op_sgn = 1'b1; end
      F_MULTU: op_mul = 1'b1;
      F_DIV:   begin op_div = 1'b1; op_sgn = 1'b1; end
      F_DIVU:  op_div = 1'b1;
      F_MTHI:  op_mthi = 1'b1;
      F_MTLO:  op_mtlo = 1'b1;
      default: ;
    endcase
    op_valid = op_mul | op_div | op_mthi | op_mtlo;
  end

  assign accept = start && op_valid && (state_q == S_IDLE || state_q == S_DONE);
  assign a_mag  = (op_sgn && A[WIDTH-1]) ? -A : A;
  assign b_mag  = (op_sgn && B[WIDTH-1]) ? -B : B;

  // Multiply step: acc holds {partial_hi, remaining multiplier}; the add carry
  // shifts into the top bit so no product bit is lost.
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

  // Divide step: acc holds {rem, quo}; the shifted remainder needs one extra bit.
  assign rem_sh   = acc_q[2*WIDTH-1:WIDTH-1];
  assign rem_ge   = (rem_sh >= {1'b0, opnd_q});
  assign rem_diff = rem_sh[WIDTH-1:0] - opnd_q;
  assign div_next = {(rem_ge ? rem_diff : rem_sh[WIDTH-1:0]), acc_q[WIDTH-2:0], rem_ge};

  assign prod_fix = neg_q  ? -acc_q : acc_q;
  assign quo_fix  = neg_q  ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rem_fix  = rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    is_div_d = is_div_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    div0_d   = div0_q;
    case (state_q)
      S_CALC: begin
        cnt_d = cnt_q - CW'(1);
        acc_d = is_div_q ? div_next : mul_next;
        if (cnt_d == '0) state_d = S_FIX;
      end
      S_FIX: begin
        if (is_div_q) begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end else begin
          {hi_d, lo_d} = prod_fix;
        end
        state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: ;
    endcase
    // A new request overrides the DONE->IDLE return, giving back-to-back issue.
    if (accept) begin
      div0_d = 1'b0;
      if (op_mthi) begin
        hi_d    = A;
        state_d = S_DONE;
      end else if (op_mtlo) begin
        lo_d    = A;
        state_d = S_DONE;
      end else if (op_div && B == '0) begin
        div0_d  = 1'b1;
        state_d = S_DONE;
      end else begin
        is_div_d = op_div;
        neg_d    = op_sgn && (A[WIDTH-1] ^ B[WIDTH-1]);
        rneg_d   = op_sgn && A[WIDTH-1];
        acc_d    = {{WIDTH{1'b0}}, (op_div ? a_mag : b_mag)};
        opnd_d   = op_div ? b_mag : a_mag;
        cnt_d    = CW'(WIDTH);
        state_d  = S_CALC;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      div0_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      is_div_q <= is_div_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      div0_q   <= div0_d;
    end
  end

  assign busy      = (state_q == S_CALC) || (state_q == S_FIX);
  assign done      = (state_q == S_DONE);
  assign div0      = done && div0_q;
  assign High      = hi_q;
  assign Low       = lo_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Directed bench for hilo_muldiv_ctrl: latency, results, div-by-zero, moves,
// ignored requests, back-to-back issue and mid-operation reset.
module tb_hilo_muldiv_ctrl;
  localparam int W = 32;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MTLO  = 6'b010011;

  logic         clk = 1'b0;
  logic         reset, start;
  logic [5:0]   op;
  logic [W-1:0] a, b;
  logic         busy, done, div0;
  logic [W-1:0] high, low;
  logic [1:0]   dbg_state;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  hilo_muldiv_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .InstructionOp(op),
    .A(a), .B(b), .busy(busy), .done(done), .div0(div0),
    .High(high), .Low(low), .dbg_state(dbg_state)
  );

  // Caller is at a negedge; after return we are at the negedge of cycle 1.
  task automatic issue(input logic [5:0] f, input logic [W-1:0] av, input logic [W-1:0] bv);
    op = f; a = av; b = bv; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // lat counts the current sample as 1; -1 on timeout. Returns at the done cycle.
  task automatic wait_done(output int lat, output int busy_n, output logic dz);
    lat = 1; busy_n = 0; dz = 1'b0;
    while (done !== 1'b1 && lat <= 100) begin
      if (busy === 1'b1) busy_n++;
      @(negedge clk);
      lat++;
    end
    if (lat > 100) lat = -1;
    else dz = div0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (div0 !== 1'b0) begin failures++; $display("FAIL reset_div0 got %b want 0", div0); end
    checks++; if (high !== '0) begin failures++; $display("FAIL reset_high got %h want 0", high); end
    checks++; if (low !== '0) begin failures++; $display("FAIL reset_low got %h want 0", low); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_multu();
    int lat, bn; logic dz;
    issue(F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_done(lat, bn, dz);
    checks++; if (lat !== 34) begin failures++; $display("FAIL multu_latency got %0d want 34", lat); end
    checks++; if (bn !== 33) begin failures++; $display("FAIL multu_busy_cycles got %0d want 33", bn); end
    checks++; if (high !== 32'hFFFFFFFE) begin failures++; $display("FAIL multu_high got %h want fffffffe", high); end
    checks++; if (low !== 32'h00000001) begin failures++; $display("FAIL multu_low got %h want 00000001", low); end
    checks++; if (dz !== 1'b0) begin failures++; $display("FAIL multu_div0 got %b want 0", dz); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL multu_done_pulse got %b want 0", done); end
  endtask

  task automatic test_mult();
    int lat, bn; logic dz;
    issue(F_MULT, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_done(lat, bn, dz);
    checks++; if (lat !== 34) begin failures++; $display("FAIL mult_latency got %0d want 34", lat); end
    checks++; if (high !== 32'h0) begin failures++; $display("FAIL mult_m1_high got %h want 0", high); end
    checks++; if (low !== 32'h1) begin failures++; $display("FAIL mult_m1_low got %h want 1", low); end
    @(negedge clk);
    issue(F_MULT, 32'd7, 32'hFFFFFFFD);
    wait_done(lat, bn, dz);
    checks++; if (high !== 32'hFFFFFFFF) begin failures++; $display("FAIL mult_neg_high got %h want ffffffff", high); end
    checks++; if (low !== 32'hFFFFFFEB) begin failures++; $display("FAIL mult_neg_low got %h want ffffffeb", low); end
    @(negedge clk);
  endtask

  task automatic test_div();
    int lat, bn; logic dz;
    issue(F_DIVU, 32'h87654321, 32'h12345678);
    wait_done(lat, bn, dz);
    checks++; if (lat !== 34) begin failures++; $display("FAIL divu_latency got %0d want 34", lat); end
    checks++; if (low !== 32'h00000007) begin failures++; $display("FAIL divu_low got %h want 00000007", low); end
    checks++; if (high !== 32'h07F6E5D9) begin failures++; $display("FAIL divu_high got %h want 07f6e5d9", high); end
    @(negedge clk);
    issue(F_DIV, 32'hFFFFFFF9, 32'd2);
    wait_done(lat, bn, dz);
    checks++; if (low !== 32'hFFFFFFFD) begin failures++; $display("FAIL div_neg_low got %h want fffffffd", low); end
    checks++; if (high !== 32'hFFFFFFFF) begin failures++; $display("FAIL div_neg_high got %h want ffffffff", high); end
    checks++; if (dz !== 1'b0) begin failures++; $display("FAIL div_neg_div0 got %b want 0", dz); end
    @(negedge clk);
  endtask

  task automatic test_div0();
    int lat, bn; logic dz;
    issue(F_MTHI, 32'hAAAA0000, 32'h0);
    wait_done(lat, bn, dz);
    issue(F_MTLO, 32'h00005555, 32'h0);
    wait_done(lat, bn, dz);
    @(negedge clk);
    issue(F_DIV, 32'd5, 32'd0);
    wait_done(lat, bn, dz);
    checks++; if (lat !== 1) begin failures++; $display("FAIL div0_latency got %0d want 1", lat); end
    checks++; if (dz !== 1'b1) begin failures++; $display("FAIL div0_flag got %b want 1", dz); end
    checks++; if (bn !== 0) begin failures++; $display("FAIL div0_busy_cycles got %0d want 0", bn); end
    checks++; if (high !== 32'hAAAA0000) begin failures++; $display("FAIL div0_high got %h want aaaa0000", high); end
    checks++; if (low !== 32'h00005555) begin failures++; $display("FAIL div0_low got %h want 00005555", low); end
    @(negedge clk);
    checks++; if (done !== 1'b0 || div0 !== 1'b0) begin failures++; $display("FAIL div0_pulse got done=%b div0=%b want 0 0", done, div0); end
    issue(F_DIV, 32'h80000000, 32'hFFFFFFFF);
    wait_done(lat, bn, dz);
    checks++; if (low !== 32'h80000000) begin failures++; $display("FAIL div_ovf_low got %h want 80000000", low); end
    checks++; if (high !== 32'h0) begin failures++; $display("FAIL div_ovf_high got %h want 0", high); end
    checks++; if (dz !== 1'b0) begin failures++; $display("FAIL div_ovf_div0 got %b want 0", dz); end
    @(negedge clk);
  endtask

  task automatic test_moves();
    int lat, bn; logic dz; logic bad;
    issue(F_MTHI, 32'h12345678, 32'h0);
    wait_done(lat, bn, dz);
    checks++; if (lat !== 1) begin failures++; $display("FAIL mthi_latency got %0d want 1", lat); end
    checks++; if (high !== 32'h12345678) begin failures++; $display("FAIL mthi_high got %h want 12345678", high); end
    @(negedge clk);
    issue(F_MTLO, 32'h87654321, 32'h0);
    wait_done(lat, bn, dz);
    checks++; if (lat !== 1) begin failures++; $display("FAIL mtlo_latency got %0d want 1", lat); end
    checks++; if (low !== 32'h87654321) begin failures++; $display("FAIL mtlo_low got %h want 87654321", low); end
    checks++; if (high !== 32'h12345678) begin failures++; $display("FAIL mtlo_high_kept got %h want 12345678", high); end
    @(negedge clk);
    issue(6'b100000, 32'hDEADBEEF, 32'h1);
    bad = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (done !== 1'b0 || busy !== 1'b0) bad = 1'b1;
      @(negedge clk);
    end
    checks++; if (bad !== 1'b0) begin failures++; $display("FAIL badfunct_activity got %b want 0", bad); end
    checks++; if (high !== 32'h12345678 || low !== 32'h87654321) begin
      failures++; $display("FAIL badfunct_regs got %h/%h want 12345678/87654321", high, low); end
  endtask

  task automatic test_back_to_back();
    int lat, bn; logic dz;
    issue(F_MULTU, 32'h12345678, 32'h00000010);
    repeat (8) @(negedge clk);
    op = F_DIV; a = 32'h11111111; b = 32'h3; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = 32'h0; b = 32'h0;
    wait_done(lat, bn, dz);
    checks++; if (lat + 9 !== 34) begin failures++; $display("FAIL busy_start_latency got %0d want 34", lat + 9); end
    checks++; if (high !== 32'h00000001) begin failures++; $display("FAIL busy_start_high got %h want 00000001", high); end
    checks++; if (low !== 32'h23456780) begin failures++; $display("FAIL busy_start_low got %h want 23456780", low); end
    issue(F_DIVU, 32'd100, 32'd7);
    wait_done(lat, bn, dz);
    checks++; if (lat !== 34) begin failures++; $display("FAIL b2b_latency got %0d want 34", lat); end
    checks++; if (low !== 32'd14) begin failures++; $display("FAIL b2b_low got %h want 0000000e", low); end
    checks++; if (high !== 32'd2) begin failures++; $display("FAIL b2b_high got %h want 00000002", high); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_op();
    logic seen;
    issue(F_DIV, 32'd1000, 32'd3);
    repeat (13) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midreset_busy got %b want 0", busy); end
    checks++; if (high !== '0 || low !== '0) begin failures++; $display("FAIL midreset_regs got %h/%h want 0/0", high, low); end
    reset = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (done !== 1'b0 || busy !== 1'b0) seen = 1'b1;
      @(negedge clk);
    end
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL midreset_no_done got %b want 0", seen); end
  endtask

  initial begin
    test_reset();
    test_multu();
    test_mult();
    test_div();
    test_div0();
    test_moves();
    test_back_to_back();
    test_reset_mid_op();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
